// File: rtl/mem_wb_skid_buffer.sv
// MEM/WB boundary register with a valid/ready handshake, a one-entry skid slot and a synchronous flush.
// occupancy_q | meaning
// 0 (EMPTY)   | nothing held, out_valid low
// 1 (ONE)     | head holds the presented entry
// 2 (FULL)    | head and skid both hold entries, in_ready low
module mem_wb_skid_buffer #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int SUPPRESS_R0 = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  memToRegI,
    input  logic                  regWriteI,
    input  logic [DATA_W-1:0]     readDataI,
    input  logic [DATA_W-1:0]     aluResultI,
    input  logic [REG_ADDR_W-1:0] writeRegistrerI,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  memToRegO,
    output logic                  regWriteO,
    output logic [DATA_W-1:0]     readDataO,
    output logic [DATA_W-1:0]     aluResultO,
    output logic [REG_ADDR_W-1:0] writeRegistrerO,
    output logic [DATA_W-1:0]     wbDataO,
    output logic [1:0]            occupancy
);

    localparam int PAY_W = 2 + 2 * DATA_W + REG_ADDR_W;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]       occ_q, occ_d;
    logic             in_ready_q, in_ready_d;
    logic [PAY_W-1:0] head_q, head_d;
    logic [PAY_W-1:0] skid_q, skid_d;
    logic [PAY_W-1:0] in_pay;
    logic             accept;
    logic             suppress_hit;

    assign in_pay = {memToRegI, regWriteI, readDataI, aluResultI, writeRegistrerI};
    assign accept = in_valid & in_ready_q;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        if (flush) begin
            // payload is left stale; occupancy alone decides visibility
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d  = OCC_ONE;
                        head_d = in_pay;
                    end
                end
                OCC_ONE: begin
                    if (accept && out_ready) begin
                        head_d = in_pay;
                    end else if (accept) begin
                        occ_d  = OCC_FULL;
                        skid_d = in_pay;
                    end else if (out_ready) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (out_ready) begin
                        occ_d  = OCC_ONE;
                        head_d = skid_q;
                    end
                end
                default: begin
                    occ_d = OCC_EMPTY;
                end
            endcase
        end
    end

    // in_ready is registered from the next occupancy so it never sees out_ready combinationally
    assign in_ready_d = (occ_d != OCC_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign occupancy       = occ_q;
    assign out_valid       = (occ_q != OCC_EMPTY);
    assign memToRegO       = head_q[PAY_W-1];
    assign readDataO       = head_q[PAY_W-3 -: DATA_W];
    assign aluResultO      = head_q[REG_ADDR_W +: DATA_W];
    assign writeRegistrerO = head_q[REG_ADDR_W-1:0];
    assign wbDataO         = memToRegO ? readDataO : aluResultO;

    assign suppress_hit = (SUPPRESS_R0 != 0) && (writeRegistrerO == '0);
    assign regWriteO    = head_q[PAY_W-2] & out_valid & ~suppress_hit;

endmodule

// File: tb/tb_mem_wb_skid_buffer.sv
// Randomised and directed bench for mem_wb_skid_buffer against a queue-based FIFO reference.
module tb_mem_wb_skid_buffer;

    typedef struct packed {
        logic        m2r;
        logic        rw;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wa;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic        memToRegI;
    logic        regWriteI;
    logic [31:0] readDataI;
    logic [31:0] aluResultI;
    logic [4:0]  writeRegistrerI;

    logic        in_ready, out_valid, memToRegO, regWriteO;
    logic [31:0] readDataO, aluResultO, wbDataO;
    logic [4:0]  writeRegistrerO;
    logic [1:0]  occupancy;

    logic        in_ready_b, out_valid_b, memToRegO_b, regWriteO_b;
    logic [31:0] readDataO_b, aluResultO_b, wbDataO_b;
    logic [4:0]  writeRegistrerO_b;
    logic [1:0]  occupancy_b;

    int checks = 0;
    int errors = 0;
    ent_t mq[$];

    mem_wb_skid_buffer #(.DATA_W(32), .REG_ADDR_W(5), .SUPPRESS_R0(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .memToRegI(memToRegI), .regWriteI(regWriteI), .readDataI(readDataI),
        .aluResultI(aluResultI), .writeRegistrerI(writeRegistrerI),
        .out_valid(out_valid), .out_ready(out_ready),
        .memToRegO(memToRegO), .regWriteO(regWriteO), .readDataO(readDataO),
        .aluResultO(aluResultO), .writeRegistrerO(writeRegistrerO),
        .wbDataO(wbDataO), .occupancy(occupancy)
    );

    mem_wb_skid_buffer #(.DATA_W(32), .REG_ADDR_W(5), .SUPPRESS_R0(0)) dut_nr0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .memToRegI(memToRegI), .regWriteI(regWriteI), .readDataI(readDataI),
        .aluResultI(aluResultI), .writeRegistrerI(writeRegistrerI),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .memToRegO(memToRegO_b), .regWriteO(regWriteO_b), .readDataO(readDataO_b),
        .aluResultO(aluResultO_b), .writeRegistrerO(writeRegistrerO_b),
        .wbDataO(wbDataO_b), .occupancy(occupancy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mk(input logic m2r, input logic rw, input logic [31:0] rd,
                                input logic [31:0] alu, input logic [4:0] wa);
        ent_t e;
        e.m2r = m2r; e.rw = rw; e.rd = rd; e.alu = alu; e.wa = wa;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.m2r = 1'($urandom_range(0, 1));
        e.rw  = 1'($urandom_range(0, 1));
        e.rd  = $urandom;
        e.alu = $urandom;
        e.wa  = 5'($urandom_range(0, 31));
        return e;
    endfunction

    // Drive one cycle of stimulus and advance the FIFO reference at the clock edge.
    task automatic step(input logic v, input logic rdy, input logic fl, input ent_t e);
        int n;
        @(negedge clk);
        in_valid = v; out_ready = rdy; flush = fl;
        memToRegI = e.m2r; regWriteI = e.rw; readDataI = e.rd;
        aluResultI = e.alu; writeRegistrerI = e.wa;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            n = mq.size();
            if (n > 0 && rdy) void'(mq.pop_front());
            if (v && n < 2) mq.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
        memToRegI = 0; regWriteI = 0; readDataI = 0; aluResultI = 0; writeRegistrerI = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, regWriteO, in_ready, occupancy} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%b rw=%b rdy=%b occ=%0d expected 0 0 1 0",
                     out_valid, regWriteO, in_ready, occupancy);
        end
        checks++;
        if ({wbDataO, readDataO, aluResultO, writeRegistrerO, memToRegO} !== '0) begin
            errors++;
            $display("FAIL reset_payload: got wb=%h rd=%h alu=%h wa=%0d m2r=%b expected all 0",
                     wbDataO, readDataO, aluResultO, writeRegistrerO, memToRegO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, mk(0, 1, $urandom, 32'h10 + i, 5'd3));
            checks++;
            if (out_valid !== 1'b1 || aluResultO !== 32'h10 + i || writeRegistrerO !== 5'd3) begin
                errors++;
                $display("FAIL stream_head%0d: got v=%b alu=%h wa=%0d expected 1 %h 3",
                         i, out_valid, aluResultO, writeRegistrerO, 32'h10 + i);
            end
            checks++;
            if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_occ%0d: got occ=%0d rdy=%b expected 1 1", i, occupancy, in_ready);
            end
        end
        step(0, 1, 0, mk(0, 0, 0, 0, 0));
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: got v=%b occ=%0d expected 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_skid();
        step(1, 0, 0, mk(0, 1, 0, 32'hA, 5'd4));
        step(1, 0, 0, mk(0, 1, 0, 32'hB, 5'd5));
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || aluResultO !== 32'hA) begin
            errors++;
            $display("FAIL skid_full: got occ=%0d rdy=%b alu=%h expected 2 0 a",
                     occupancy, in_ready, aluResultO);
        end
        step(1, 0, 0, mk(0, 1, 0, 32'hC, 5'd6));
        checks++;
        if (occupancy !== 2'd2 || aluResultO !== 32'hA || writeRegistrerO !== 5'd4) begin
            errors++;
            $display("FAIL skid_ignore_c: got occ=%0d alu=%h wa=%0d expected 2 a 4",
                     occupancy, aluResultO, writeRegistrerO);
        end
        step(0, 1, 0, mk(0, 0, 0, 0, 0));
        checks++;
        if (out_valid !== 1'b1 || aluResultO !== 32'hB || writeRegistrerO !== 5'd5 ||
            occupancy !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid_b: got v=%b alu=%h wa=%0d occ=%0d rdy=%b expected 1 b 5 1 1",
                     out_valid, aluResultO, writeRegistrerO, occupancy, in_ready);
        end
        step(0, 1, 0, mk(0, 0, 0, 0, 0));
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL skid_no_c: got v=%b occ=%0d alu=%h expected empty",
                     out_valid, occupancy, aluResultO);
        end
    endtask

    task automatic test_wbdata();
        step(1, 1, 0, mk(1, 1, 32'hDEADBEEF, 32'h1234, 5'd8));
        checks++;
        if (wbDataO !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wbdata_mem: got %h expected deadbeef", wbDataO);
        end
        step(1, 1, 0, mk(0, 1, 32'hDEADBEEF, 32'h1234, 5'd8));
        checks++;
        if (wbDataO !== 32'h1234) begin
            errors++;
            $display("FAIL wbdata_alu: got %h expected 00001234", wbDataO);
        end
        step(0, 1, 0, mk(0, 0, 0, 0, 0));
    endtask

    task automatic test_r0();
        step(1, 1, 0, mk(0, 1, 0, 32'h55, 5'd0));
        checks++;
        if (regWriteO !== 1'b0) begin
            errors++;
            $display("FAIL r0_suppress: got regWriteO=%b expected 0", regWriteO);
        end
        checks++;
        if (regWriteO_b !== 1'b1) begin
            errors++;
            $display("FAIL r0_nosuppress: got regWriteO=%b expected 1", regWriteO_b);
        end
        step(1, 1, 0, mk(0, 1, 0, 32'h56, 5'd7));
        checks++;
        if (regWriteO !== 1'b1) begin
            errors++;
            $display("FAIL r0_nonzero: got regWriteO=%b expected 1", regWriteO);
        end
        step(0, 1, 0, mk(0, 0, 0, 0, 0));
        checks++;
        if (regWriteO !== 1'b0 || regWriteO_b !== 1'b0) begin
            errors++;
            $display("FAIL r0_invalid: got %b/%b expected 0/0", regWriteO, regWriteO_b);
        end
    endtask

    task automatic test_flush();
        step(1, 0, 0, mk(0, 1, 0, 32'hE1, 5'd9));
        step(1, 0, 0, mk(0, 1, 0, 32'hE2, 5'd10));
        step(1, 0, 1, mk(0, 1, 0, 32'hF1, 5'd11));
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || regWriteO !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got occ=%0d v=%b rw=%b rdy=%b expected 0 0 0 1",
                     occupancy, out_valid, regWriteO, in_ready);
        end
        step(0, 1, 0, mk(0, 0, 0, 0, 0));
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL flush_discard: got v=%b occ=%0d expected 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, mk(1, 1, 32'h77, 32'h88, 5'd12));
        step(1, 0, 0, mk(0, 1, 32'h99, 32'hAA, 5'd13));
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        checks++;
        if ({out_valid, regWriteO, in_ready, occupancy} !== 5'b00100 || wbDataO !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got v=%b rw=%b rdy=%b occ=%0d wb=%h expected 0 0 1 0 0",
                     out_valid, regWriteO, in_ready, occupancy, wbDataO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, mk(0, 1, 0, 32'h3C, 5'd14));
        checks++;
        if (out_valid !== 1'b1 || aluResultO !== 32'h3C || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_entry: got v=%b alu=%h occ=%0d expected 1 3c 1",
                     out_valid, aluResultO, occupancy);
        end
        step(0, 1, 0, mk(0, 0, 0, 0, 0));
    endtask

    task automatic test_random();
        ent_t h;
        logic exp_rw;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 24) == 0), rnd_ent());
            checks++;
            if (out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size()) ||
                in_ready !== (mq.size() < 2)) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got v=%b occ=%0d rdy=%b expected occ=%0d",
                         i, out_valid, occupancy, in_ready, mq.size());
            end
            if (mq.size() > 0) begin
                h = mq[0];
                exp_rw = h.rw && (h.wa != 5'd0);
                checks++;
                if (aluResultO !== h.alu || readDataO !== h.rd || writeRegistrerO !== h.wa ||
                    memToRegO !== h.m2r || wbDataO !== (h.m2r ? h.rd : h.alu) ||
                    regWriteO !== exp_rw || regWriteO_b !== h.rw) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: got alu=%h rd=%h wa=%0d m2r=%b rw=%b/%b expected alu=%h rd=%h wa=%0d m2r=%b rw=%b/%b",
                             i, aluResultO, readDataO, writeRegistrerO, memToRegO, regWriteO, regWriteO_b,
                             h.alu, h.rd, h.wa, h.m2r, exp_rw, h.rw);
                end
            end else begin
                checks++;
                if (regWriteO !== 1'b0 || regWriteO_b !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_rw_idle[%0d]: got %b/%b expected 0/0", i, regWriteO, regWriteO_b);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_wbdata();
        test_r0();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
